// File: rtl/mesi_line_ctrl.sv
// MESI coherence controller for a direct-mapped cache. It owns the tag/state array and
// sequences victim writebacks and bus transactions for processor requests. It also snoops
// foreign bus traffic every cycle.
module mesi_line_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 4,
  parameter int unsigned OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pr_valid,
  input  logic              pr_op,
  input  logic [ADDR_W-1:0] pr_addr,
  output logic              pr_ready,
  output logic              pr_done,
  output logic              pr_hit,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ack,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic              bus_shared,
  input  logic              snp_valid,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_shared_out,
  output logic              snp_hitm_out
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_W;
  localparam int unsigned LINES  = 1 << INDEX_W;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_RDX  = 2'd2;
  localparam logic [1:0] OP_UPGR = 2'd3;

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StArb, StBus, StDone} fsm_e;

  fsm_e               fsm_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [1:0]         st_q  [LINES];
  logic               op_q;
  logic [LINE_W-1:0]  line_q;
  logic [1:0]         pend_op_q;
  logic               pr_done_q, pr_hit_q, wb_req_q, bus_req_q;
  logic [1:0]         bus_op_q;
  logic [ADDR_W-1:0]  wb_addr_q, bus_addr_q;
  logic               snp_shared_q, snp_hitm_q;

  // Byte offsets never affect coherence decisions.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{pr_addr[OFFSET_W-1:0], snp_addr[OFFSET_W-1:0]};

  logic [INDEX_W-1:0] req_idx, snp_idx;
  logic [TAG_W-1:0]   req_tag, snp_tag, cur_tag;
  logic [1:0]         cur_st, snp_st;
  logic               cur_hit;

  assign req_idx = line_q[INDEX_W-1:0];
  assign req_tag = line_q[LINE_W-1:INDEX_W];
  assign cur_st  = st_q[req_idx];
  assign cur_tag = tag_q[req_idx];
  assign cur_hit = (cur_st != ST_I) && (cur_tag == req_tag);

  assign snp_idx = snp_addr[OFFSET_W +: INDEX_W];
  assign snp_tag = snp_addr[ADDR_W-1 -: TAG_W];
  assign snp_st  = st_q[snp_idx];

  logic       snp_wr, snp_sh, snp_hm, snp_kills_tgt;
  logic [1:0] snp_new;

  // Snoop response: next state of the snooped line plus the flags to report.
  always_comb begin
    snp_wr  = 1'b0;
    snp_new = snp_st;
    snp_sh  = 1'b0;
    snp_hm  = 1'b0;
    if (snp_valid && (snp_st != ST_I) && (tag_q[snp_idx] == snp_tag)) begin
      case (snp_op)
        OP_RD: begin
          snp_wr  = 1'b1;
          snp_new = ST_S;
          snp_sh  = 1'b1;
          snp_hm  = (snp_st == ST_M);
        end
        OP_RDX: begin
          snp_wr  = 1'b1;
          snp_new = ST_I;
          snp_hm  = (snp_st == ST_M);
          snp_sh  = (snp_st != ST_M);
        end
        OP_UPGR: begin
          if (snp_st == ST_S) begin
            snp_wr  = 1'b1;
            snp_new = ST_I;
            snp_sh  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A foreign invalidation of our target line turns a pending upgrade into a full RdX.
  assign snp_kills_tgt = snp_wr && (snp_new == ST_I) && (snp_idx == req_idx) &&
                         (snp_tag == req_tag);

  logic             loc_wr;
  logic [TAG_W-1:0] loc_tag;
  logic [1:0]       loc_st;

  // Local array update requested by the request FSM this cycle.
  always_comb begin
    loc_wr  = 1'b0;
    loc_tag = req_tag;
    loc_st  = ST_I;
    case (fsm_q)
      StLookup: begin
        if (op_q && cur_hit && (cur_st == ST_E)) begin
          loc_wr = 1'b1;
          loc_st = ST_M;
        end
      end
      StWb: begin
        if (wb_ack) begin
          loc_wr  = 1'b1;
          loc_tag = cur_tag;
          loc_st  = ST_I;
        end
      end
      StBus: begin
        if (bus_ack) begin
          loc_wr = 1'b1;
          loc_st = (pend_op_q == OP_RD) ? (bus_shared ? ST_S : ST_E) : ST_M;
        end
      end
      default: ;
    endcase
  end

  // Tag/state array; the local write is applied last so it wins on a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '{default: '0};
      st_q  <= '{default: ST_I};
    end else begin
      if (snp_wr) st_q[snp_idx] <= snp_new;
      if (loc_wr) begin
        tag_q[req_idx] <= loc_tag;
        st_q[req_idx]  <= loc_st;
      end
    end
  end

  // Registered snoop flags, one cycle after snp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      snp_shared_q <= 1'b0;
      snp_hitm_q   <= 1'b0;
    end else begin
      snp_shared_q <= snp_sh;
      snp_hitm_q   <= snp_hm;
    end
  end

  logic [1:0] arb_op;
  assign arb_op = ((pend_op_q == OP_UPGR) && snp_kills_tgt) ? OP_RDX : pend_op_q;

  // Request FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= StIdle;
      op_q       <= 1'b0;
      line_q     <= '0;
      pend_op_q  <= OP_NONE;
      pr_done_q  <= 1'b0;
      pr_hit_q   <= 1'b0;
      wb_req_q   <= 1'b0;
      wb_addr_q  <= '0;
      bus_req_q  <= 1'b0;
      bus_op_q   <= OP_NONE;
      bus_addr_q <= '0;
    end else begin
      pr_done_q <= 1'b0;
      pr_hit_q  <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (pr_valid) begin
            op_q   <= pr_op;
            line_q <= pr_addr[ADDR_W-1:OFFSET_W];
            fsm_q  <= StLookup;
          end
        end
        StLookup: begin
          if (cur_hit && (!op_q || (cur_st != ST_S))) begin
            fsm_q     <= StDone;
            pr_done_q <= 1'b1;
            pr_hit_q  <= 1'b1;
          end else if (cur_hit) begin
            pend_op_q <= snp_kills_tgt ? OP_RDX : OP_UPGR;
            bus_req_q <= 1'b1;
            fsm_q     <= StArb;
          end else if (cur_st == ST_M) begin
            pend_op_q <= op_q ? OP_RDX : OP_RD;
            wb_req_q  <= 1'b1;
            wb_addr_q <= {cur_tag, req_idx, {OFFSET_W{1'b0}}};
            fsm_q     <= StWb;
          end else begin
            pend_op_q <= op_q ? OP_RDX : OP_RD;
            bus_req_q <= 1'b1;
            fsm_q     <= StArb;
          end
        end
        StWb: begin
          if (wb_ack) begin
            wb_req_q  <= 1'b0;
            bus_req_q <= 1'b1;
            fsm_q     <= StArb;
          end
        end
        StArb: begin
          pend_op_q <= arb_op;
          if (bus_gnt) begin
            bus_op_q   <= arb_op;
            bus_addr_q <= {line_q, {OFFSET_W{1'b0}}};
            fsm_q      <= StBus;
          end
        end
        StBus: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            bus_op_q  <= OP_NONE;
            pr_done_q <= 1'b1;
            fsm_q     <= StDone;
          end
        end
        StDone:  fsm_q <= StIdle;
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign pr_ready       = pr_valid && (fsm_q == StIdle);
  assign pr_done        = pr_done_q;
  assign pr_hit         = pr_hit_q;
  assign wb_req         = wb_req_q;
  assign wb_addr        = wb_addr_q;
  assign bus_req        = bus_req_q;
  assign bus_op         = bus_op_q;
  assign bus_addr       = bus_addr_q;
  assign snp_shared_out = snp_shared_q;
  assign snp_hitm_out   = snp_hitm_q;

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// Self-checking bench for mesi_line_ctrl: directed vector table, hand-written ARB/reset
// sequence, then random requests and snoops against a line-level MESI reference model.
module tb_mesi_line_ctrl;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_RDX  = 2'd2;
  localparam logic [1:0] OP_UPGR = 2'd3;
  localparam int ST_I = 0, ST_S = 1, ST_E = 2, ST_M = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pr_valid, pr_op, pr_ready, pr_done, pr_hit;
  logic [31:0] pr_addr, wb_addr, bus_addr, snp_addr;
  logic        wb_req, wb_ack, bus_req, bus_gnt, bus_ack, bus_shared;
  logic [1:0]  bus_op, snp_op;
  logic        snp_valid, snp_shared_out, snp_hitm_out;

  always #5 clk = ~clk;

  mesi_line_ctrl #(.ADDR_W(32), .INDEX_W(4), .OFFSET_W(6)) dut (
    .clk(clk), .rst(rst),
    .pr_valid(pr_valid), .pr_op(pr_op), .pr_addr(pr_addr), .pr_ready(pr_ready),
    .pr_done(pr_done), .pr_hit(pr_hit),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_shared(bus_shared),
    .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr),
    .snp_shared_out(snp_shared_out), .snp_hitm_out(snp_hitm_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one MESI state and tag per line index.
  int m_st  [16];
  int m_tag [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i]  = ST_I;
      m_tag[i] = 0;
    end
  endtask

  task automatic model_req(input bit op, input logic [31:0] addr, input bit shared,
                           output bit hit, output bit wb, output logic [31:0] wb_a,
                           output logic [1:0] bop);
    int idx, tag;
    idx  = int'(addr[9:6]);
    tag  = int'(addr[31:10]);
    hit  = 0;
    wb   = 0;
    wb_a = 32'h0;
    bop  = OP_NONE;
    if (m_st[idx] != ST_I && m_tag[idx] == tag) begin
      if (!op) hit = 1;
      else if (m_st[idx] == ST_S) begin
        bop = OP_UPGR;
        m_st[idx] = ST_M;
      end else begin
        hit = 1;
        m_st[idx] = ST_M;
      end
    end else begin
      if (m_st[idx] == ST_M) begin
        wb   = 1;
        wb_a = 32'(m_tag[idx] * 1024 + idx * 64);
      end
      bop = op ? OP_RDX : OP_RD;
      m_tag[idx] = tag;
      m_st[idx]  = op ? ST_M : (shared ? ST_S : ST_E);
    end
  endtask

  task automatic model_snoop(input logic [1:0] op, input logic [31:0] addr,
                             output bit sh, output bit hm);
    int idx, tag;
    idx = int'(addr[9:6]);
    tag = int'(addr[31:10]);
    sh  = 0;
    hm  = 0;
    if (m_st[idx] != ST_I && m_tag[idx] == tag) begin
      if (op == OP_RD) begin
        hm = (m_st[idx] == ST_M);
        sh = 1;
        m_st[idx] = ST_S;
      end else if (op == OP_RDX) begin
        hm = (m_st[idx] == ST_M);
        sh = !hm;
        m_st[idx] = ST_I;
      end else if (op == OP_UPGR && m_st[idx] == ST_S) begin
        sh = 1;
        m_st[idx] = ST_I;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctl"}, {23'b0, pr_ready, pr_done, pr_hit, wb_req, bus_req, bus_op,
                           snp_shared_out, snp_hitm_out}, 32'h0);
    check({name, " wb_addr"}, wb_addr, 32'h0);
    check({name, " bus_addr"}, bus_addr, 32'h0);
  endtask

  // Issue one request from an idle DUT (called at a negedge) and act as the bus/memory agent.
  task automatic do_req(input string name, input bit op, input logic [31:0] addr,
                        input bit shared, input int gnt_dly, input int ack_dly, input int wb_dly,
                        input bit exp_hit, input bit exp_wb, input logic [31:0] exp_wb_addr,
                        input logic [1:0] exp_bop);
    bit          seen_done, seen_wb, seen_breq, unstable, hit;
    logic [31:0] wb_a, bus_a;
    logic [1:0]  first_op;
    int          wb_n, arb_n, bus_n, ack_cyc, done_cyc;
    seen_done = 0; seen_wb = 0; seen_breq = 0; unstable = 0; hit = 0;
    wb_a = 32'h0; bus_a = 32'h0; first_op = OP_NONE;
    wb_n = 0; arb_n = 0; bus_n = 0; ack_cyc = -10; done_cyc = -10;
    pr_valid = 1'b1;
    pr_op    = op;
    pr_addr  = addr;
    #1;
    check({name, " pr_ready"}, 32'(pr_ready), 32'h1);
    @(negedge clk);
    pr_valid = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
      wb_ack = 1'b0; bus_gnt = 1'b0; bus_ack = 1'b0; bus_shared = 1'b0;
      if (pr_done) begin
        seen_done = 1;
        hit       = pr_hit;
        done_cyc  = cyc;
      end else begin
        if (wb_req) begin
          if (seen_wb && wb_addr !== wb_a) unstable = 1;
          seen_wb = 1;
          wb_a    = wb_addr;
          wb_n++;
          if (wb_n > wb_dly) wb_ack = 1'b1;
        end
        if (bus_req) seen_breq = 1;
        if (bus_req && bus_op == OP_NONE) begin
          arb_n++;
          if (arb_n > gnt_dly) bus_gnt = 1'b1;
        end
        if (bus_op != OP_NONE) begin
          if (bus_n == 0) begin
            first_op = bus_op;
            bus_a    = bus_addr;
          end else if (bus_op !== first_op || bus_addr !== bus_a) begin
            unstable = 1;
          end
          if (!bus_req) unstable = 1;
          bus_n++;
          if (bus_n > ack_dly) begin
            bus_ack    = 1'b1;
            bus_shared = shared;
            ack_cyc    = cyc;
          end
        end
        @(negedge clk);
      end
    end
    check({name, " done"}, 32'(seen_done), 32'h1);
    check({name, " hit"}, 32'(hit), 32'(exp_hit));
    check({name, " wb"}, 32'(seen_wb), 32'(exp_wb));
    if (exp_wb) check({name, " wb_addr"}, wb_a, exp_wb_addr);
    check({name, " bus_op"}, 32'(first_op), 32'(exp_bop));
    check({name, " bus_req"}, 32'(seen_breq), 32'(exp_bop != OP_NONE));
    if (exp_bop != OP_NONE) check({name, " bus_addr"}, bus_a, addr & 32'hFFFF_FFC0);
    check({name, " stable"}, 32'(unstable), 32'h0);
    if (exp_hit) check({name, " hit latency"}, 32'(done_cyc), 32'd2);
    else check({name, " miss latency"}, 32'(done_cyc), 32'(ack_cyc + 1));
    @(negedge clk);
  endtask

  task automatic do_snoop(input string name, input logic [1:0] op, input logic [31:0] addr,
                          input bit exp_sh, input bit exp_hm);
    snp_valid = 1'b1;
    snp_op    = op;
    snp_addr  = addr;
    @(negedge clk);
    snp_valid = 1'b0;
    check({name, " snp_shared"}, 32'(snp_shared_out), 32'(exp_sh));
    check({name, " snp_hitm"}, 32'(snp_hitm_out), 32'(exp_hm));
  endtask

  typedef struct {
    bit          is_snp;
    bit          op_w;
    logic [1:0]  sop;
    logic [31:0] addr;
    bit          shared;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [1:0]  exp_bop;
    bit          exp_sh;
    bit          exp_hm;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit          got, e_hit, e_wb, e_sh, e_hm;
    logic [31:0] e_wb_a, a;
    logic [1:0]  e_bop, sop;

    // Directed sequence: each entry runs from an idle DUT.
    vecs[0] = '{0, 0, OP_NONE, 32'h0000_0040, 0, 0, 0, 32'h0,          OP_RD,   0, 0};
    vecs[1] = '{0, 0, OP_NONE, 32'h0000_0040, 0, 1, 0, 32'h0,          OP_NONE, 0, 0};
    vecs[2] = '{0, 1, OP_NONE, 32'h0000_0040, 0, 1, 0, 32'h0,          OP_NONE, 0, 0};
    vecs[3] = '{0, 0, OP_NONE, 32'h0000_0440, 1, 0, 1, 32'h0000_0040, OP_RD,   0, 0};
    vecs[4] = '{0, 1, OP_NONE, 32'h0000_0440, 0, 0, 0, 32'h0,          OP_UPGR, 0, 0};
    vecs[5] = '{1, 0, OP_RD,   32'h0000_0440, 0, 0, 0, 32'h0,          OP_NONE, 1, 1};
    vecs[6] = '{1, 0, OP_RDX,  32'h0000_0440, 0, 0, 0, 32'h0,          OP_NONE, 1, 0};
    vecs[7] = '{0, 0, OP_NONE, 32'h0000_0440, 0, 0, 0, 32'h0,          OP_RD,   0, 0};
    vecs[8] = '{1, 0, OP_RD,   32'h0000_0840, 0, 0, 0, 32'h0,          OP_NONE, 0, 0};

    rst = 1'b1; pr_valid = 1'b0; pr_op = 1'b0; pr_addr = 32'h0;
    wb_ack = 1'b0; bus_gnt = 1'b0; bus_ack = 1'b0; bus_shared = 1'b0;
    snp_valid = 1'b0; snp_op = OP_NONE; snp_addr = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_snp)
        do_snoop($sformatf("vec%0d", i), vecs[i].sop, vecs[i].addr, vecs[i].exp_sh,
                 vecs[i].exp_hm);
      else
        do_req($sformatf("vec%0d", i), vecs[i].op_w, vecs[i].addr, vecs[i].shared,
               i % 3, (i + 1) % 3, i % 2, vecs[i].exp_hit, vecs[i].exp_wb,
               vecs[i].exp_wb_addr, vecs[i].exp_bop);
    end

    // Pending upgrade killed by a foreign RdX while waiting for the grant, then reset in BUS.
    do_req("upg setup", 1'b0, 32'h0000_0080, 1'b1, 0, 0, 0, 1'b0, 1'b0, 32'h0, OP_RD);
    pr_valid = 1'b1; pr_op = 1'b1; pr_addr = 32'h0000_0080;
    @(negedge clk);
    pr_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus_req) got = 1;
      else @(negedge clk);
    end
    check("upg reach arb", 32'(got), 32'h1);
    snp_valid = 1'b1; snp_op = OP_RDX; snp_addr = 32'h0000_0080;
    @(negedge clk);
    snp_valid = 1'b0;
    check("upg snoop shared", 32'(snp_shared_out), 32'h1);
    check("upg snoop hitm", 32'(snp_hitm_out), 32'h0);
    @(negedge clk);
    check("upg arb holds req", 32'(bus_req), 32'h1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    check("upg converted op", 32'(bus_op), 32'(OP_RDX));
    check("upg bus_addr", bus_addr, 32'h0000_0080);
    check("upg bus_req in bus", 32'(bus_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset in bus");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after reset");
    do_snoop("post reset snoop", OP_RD, 32'h0000_0440, 1'b0, 1'b0);
    do_req("post reset read", 1'b0, 32'h0000_0040, 1'b0, 1, 0, 0, 1'b0, 1'b0, 32'h0, OP_RD);

    // Random traffic against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      int idx, tg;
      idx = int'($urandom_range(0, 3));
      tg  = int'($urandom_range(0, 2));
      a   = 32'(tg * 1024 + idx * 64 + int'($urandom_range(0, 63)));
      if ($urandom_range(0, 3) == 0) begin
        if (m_st[idx] == ST_S && m_tag[idx] == tg && $urandom_range(0, 1) == 1) sop = OP_UPGR;
        else sop = ($urandom_range(0, 1) == 1) ? OP_RDX : OP_RD;
        model_snoop(sop, a, e_sh, e_hm);
        do_snoop($sformatf("rnd%0d", i), sop, a, e_sh, e_hm);
      end else begin
        bit op, sh;
        op = 1'($urandom_range(0, 1));
        sh = 1'($urandom_range(0, 1));
        model_req(op, a, sh, e_hit, e_wb, e_wb_a, e_bop);
        do_req($sformatf("rnd%0d", i), op, a, sh, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               e_hit, e_wb, e_wb_a, e_bop);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
